mc_ctrl_irq: RTL

Parametrised multi-cycle control unit for the MIPS microsystem CPU: decodes the instruction register, sequences the datapath through fetch/decode/execute/memory/write-back states and drives every datapath and CP0 strobe. It extends the previous controller in four ways: memory wait states (`mem_rdy` handshake), `NIRQ` maskable interrupt lines with a global enable, a reserved-instruction exception, and the extra instructions `and`, `andi` and `bne`. It sits between the IR/datapath and CP0.

---
 rtl/mc_ctrl_irq.sv | 238 +++++++++++++++++++++++
 1 files changed

// File: rtl/mc_ctrl_irq.sv
// rtl/mc_ctrl_irq.sv - multi-cycle MIPS control unit with wait states, interrupts and reserved-instruction trap
module mc_ctrl_irq #(
    parameter int NIRQ    = 6,
    parameter int RI_CODE = 10
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     instr,
    input  logic            zero,
    input  logic            mem_rdy,
    input  logic [NIRQ-1:0] irq,
    input  logic [NIRQ-1:0] im,
    input  logic            ie,
    input  logic            exl,
    output logic [3:0]      fsm,
    output logic            pcwr,
    output logic            irwr,
    output logic            regwrite,
    output logic            alusrc,
    output logic            memread,
    output logic            memwrite,
    output logic            isbyte,
    output logic [2:0]      npc_sel,
    output logic [1:0]      regdst,
    output logic [2:0]      memtoreg,
    output logic [1:0]      ext_op,
    output logic [2:0]      alu_ctr,
    output logic            cp0_wen,
    output logic            epcwr,
    output logic            exlset,
    output logic            exlclr,
    output logic [4:0]      exc_code
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_WBMEM  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXE    = 4'd6,
        S_WBALU  = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_INT    = 4'd10,
        S_EXC    = 4'd11
    } state_t;

    localparam logic [4:0] RI = 5'(RI_CODE);

    state_t state;

    logic [5:0] op;
    logic [5:0] funct;
    logic [4:0] rs;
    logic       unused_fields;

    assign op            = instr[31:26];
    assign funct         = instr[5:0];
    assign rs            = instr[25:21];
    assign unused_fields = ^instr[20:6];

    logic rtype, cop0;
    logic i_addu, i_subu, i_slt, i_and, i_jr;
    logic i_addi, i_addiu, i_andi, i_ori, i_lui;
    logic i_lw, i_lb, i_sw, i_sb;
    logic i_beq, i_bne, i_j, i_jal;
    logic i_eret, i_mfc0, i_mtc0;

    assign rtype   = (op == 6'h00);
    assign cop0    = (op == 6'h10);
    assign i_addu  = rtype && (funct == 6'h21);
    assign i_subu  = rtype && (funct == 6'h23);
    assign i_slt   = rtype && (funct == 6'h2a);
    assign i_and   = rtype && (funct == 6'h24);
    assign i_jr    = rtype && (funct == 6'h08);
    assign i_addi  = (op == 6'h08);
    assign i_addiu = (op == 6'h09);
    assign i_andi  = (op == 6'h0c);
    assign i_ori   = (op == 6'h0d);
    assign i_lui   = (op == 6'h0f);
    assign i_lw    = (op == 6'h23);
    assign i_lb    = (op == 6'h20);
    assign i_sw    = (op == 6'h2b);
    assign i_sb    = (op == 6'h28);
    assign i_beq   = (op == 6'h04);
    assign i_bne   = (op == 6'h05);
    assign i_j     = (op == 6'h02);
    assign i_jal   = (op == 6'h03);
    assign i_eret  = cop0 && (rs == 5'h10) && (funct == 6'h18);
    assign i_mfc0  = cop0 && (rs == 5'h00);
    assign i_mtc0  = cop0 && (rs == 5'h04);

    logic c_ralu, c_imm, c_load, c_store, c_branch, c_jump, c_cp0;

    assign c_ralu   = i_addu | i_subu | i_slt | i_and;
    assign c_imm    = i_addi | i_addiu | i_andi | i_ori | i_lui;
    assign c_load   = i_lw | i_lb;
    assign c_store  = i_sw | i_sb;
    assign c_branch = i_beq | i_bne;
    assign c_jump   = i_j | i_jal | i_jr | i_eret;
    assign c_cp0    = i_mfc0 | i_mtc0;

    // eret clears EXL in the same cycle, so its interrupt check ignores exl
    logic req_any, pend_now, complete;

    assign req_any  = |(irq & im);
    assign pend_now = req_any && ie && ((state == S_JUMP && i_eret) || !exl);
    assign complete = (state == S_WBMEM) || (state == S_WBALU) ||
                      (state == S_BRANCH) || (state == S_JUMP) ||
                      (state == S_MEMWR && mem_rdy);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_FETCH;
            exc_code <= 5'd0;
        end else if (complete) begin
            if (pend_now) begin
                state    <= S_INT;
                exc_code <= 5'd0;
            end else begin
                state    <= S_FETCH;
            end
        end else begin
            case (state)
                S_FETCH:  if (mem_rdy) state <= S_DECODE;
                S_DECODE: begin
                    if (c_ralu || c_imm || c_cp0)  state <= S_EXE;
                    else if (c_branch)             state <= S_BRANCH;
                    else if (c_jump)               state <= S_JUMP;
                    else if (c_load || c_store)    state <= S_MEMADR;
                    else begin
                        state    <= S_EXC;
                        exc_code <= RI;
                    end
                end
                S_MEMADR: state <= c_load ? S_MEMRD : S_MEMWR;
                S_MEMRD:  if (mem_rdy) state <= S_WBMEM;
                S_MEMWR:  state <= S_MEMWR;
                S_EXE:    state <= S_WBALU;
                default:  state <= S_FETCH;
            endcase
        end
    end

    assign fsm = state;

    logic [2:0] alu_op;

    always_comb begin
        alu_op = 3'b000;
        if (i_subu)                alu_op = 3'b001;
        else if (i_slt)            alu_op = 3'b011;
        else if (i_and || i_andi)  alu_op = 3'b100;
        else if (i_ori || i_lui)   alu_op = 3'b010;
    end

    always_comb begin
        pcwr     = 1'b0;
        irwr     = 1'b0;
        regwrite = 1'b0;
        alusrc   = 1'b0;
        memread  = 1'b0;
        memwrite = 1'b0;
        isbyte   = 1'b0;
        npc_sel  = 3'b000;
        regdst   = 2'b00;
        memtoreg = 3'b000;
        ext_op   = 2'b00;
        alu_ctr  = 3'b000;
        cp0_wen  = 1'b0;
        epcwr    = 1'b0;
        exlset   = 1'b0;
        exlclr   = 1'b0;
        case (state)
            S_FETCH: begin
                memread = 1'b1;
                pcwr    = mem_rdy;
                irwr    = mem_rdy;
            end
            S_MEMADR: begin
                alusrc = 1'b1;
                ext_op = 2'b01;
            end
            S_MEMRD: begin
                memread = 1'b1;
                isbyte  = i_lb;
            end
            S_WBMEM: begin
                regwrite = 1'b1;
                memtoreg = 3'b001;
            end
            S_MEMWR: begin
                memwrite = 1'b1;
                isbyte   = i_sb;
            end
            S_EXE: begin
                alusrc  = c_imm;
                alu_ctr = alu_op;
                if (i_lui)                ext_op = 2'b10;
                else if (i_andi || i_ori) ext_op = 2'b00;
                else if (c_imm)           ext_op = 2'b01;
            end
            S_WBALU: begin
                regwrite = c_ralu | c_imm | i_mfc0;
                regdst   = c_ralu ? 2'b01 : 2'b00;
                memtoreg = i_mfc0 ? 3'b011 : 3'b000;
                cp0_wen  = i_mtc0;
            end
            S_BRANCH: begin
                alu_ctr = 3'b001;
                npc_sel = 3'b001;
                pcwr    = (i_beq && zero) || (i_bne && !zero);
            end
            S_JUMP: begin
                pcwr   = 1'b1;
                exlclr = i_eret;
                if (i_jr)        npc_sel = 3'b011;
                else if (i_eret) npc_sel = 3'b101;
                else             npc_sel = 3'b010;
                if (i_jal) begin
                    regwrite = 1'b1;
                    regdst   = 2'b10;
                    memtoreg = 3'b010;
                end
            end
            S_INT, S_EXC: begin
                pcwr    = 1'b1;
                npc_sel = 3'b100;
                epcwr   = 1'b1;
                exlset  = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
